led_count_ctrl: RTL and testbench

Command-driven controller for the board's 8-bit LED counter datapath. It owns the prescaler and the LED count register and sequences them through run/pause states. Host logic (UART decoder or button front-end) drives it over a valid/ready command port to start, stop, clear, load, reverse direction and change rate. It replaces free-running counting with a controllable, observable counter for the top level.

---
 rtl/led_count_ctrl.sv | 143 ++++++++++++++
 tb/tb_led_count_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_count_ctrl.sv
// Command-driven controller for the 8-bit LED counter: a run/pause FSM that
// owns the prescaler, the count register and a one-command-per-two-cycles port.
module led_count_ctrl #(
  parameter int unsigned CLK_FREQ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] leds,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_START    = 3'd1,
    OP_STOP     = 3'd2,
    OP_CLEAR    = 3'd3,
    OP_LOAD     = 3'd4,
    OP_SET_DIR  = 3'd5,
    OP_SET_RATE = 3'd6,
    OP_RSVD     = 3'd7
  } op_t;

  localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);

  state_t      state_q, state_d;
  logic [31:0] pre_q, pre_d;
  logic [7:0]  leds_q, leds_d;
  logic        dir_q, dir_d;
  logic [1:0]  rate_q, rate_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic        ready_q, ready_d;

  logic [31:0] pre_last;
  logic        accept;
  logic        step_due;
  logic        step_blocked;
  op_t         op;

  assign pre_last = (CLK_FREQ_W >> rate_q) - 32'd1;
  assign accept   = cmd_valid && ready_q;
  assign op       = op_t'(cmd_op);
  assign step_due = (state_q == S_RUN) && (pre_q == pre_last);

  // Commands that rewrite the count or stop the counter take the cycle away
  // from a coinciding step; the rest let the step through with the old dir.
  always_comb begin
    step_blocked = 1'b0;
    if (accept) begin
      case (op)
        OP_STOP, OP_CLEAR, OP_LOAD, OP_SET_RATE: step_blocked = 1'b1;
        default:                                 step_blocked = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    leds_d  = leds_q;
    dir_d   = dir_q;
    rate_d  = rate_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    ready_d = !accept;

    if (state_q == S_RUN) begin
      if (!step_due) begin
        pre_d = pre_q + 32'd1;
      end else if (!step_blocked) begin
        pre_d  = '0;
        leds_d = dir_q ? (leds_q - 8'd1) : (leds_q + 8'd1);
        tick_d = 1'b1;
        wrap_d = dir_q ? (leds_q == 8'h00) : (leds_q == 8'hFF);
      end
    end

    if (accept) begin
      case (op)
        OP_START: state_d = S_RUN;
        // Holding pre (at P-1 on a collision) means no phase is lost on resume.
        OP_STOP: begin
          state_d = S_IDLE;
          pre_d   = pre_q;
        end
        OP_CLEAR: begin
          leds_d = '0;
          pre_d  = '0;
        end
        OP_LOAD: begin
          leds_d = cmd_data;
          pre_d  = '0;
        end
        OP_SET_DIR: dir_d = cmd_data[0];
        OP_SET_RATE: begin
          rate_d = cmd_data[1:0];
          pre_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      leds_q  <= '0;
      dir_q   <= 1'b0;
      rate_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
      rate_q  <= rate_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign leds      = leds_q;
  assign running   = (state_q == S_RUN);
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Directed bench for led_count_ctrl at CLK_FREQ = 8: a per-cycle vector table
// followed by hand-written rate/direction and back-to-back handshake sequences.
module tb_led_count_ctrl;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_START    = 3'd1;
  localparam logic [2:0] OP_STOP     = 3'd2;
  localparam logic [2:0] OP_CLEAR    = 3'd3;
  localparam logic [2:0] OP_LOAD     = 3'd4;
  localparam logic [2:0] OP_SET_DIR  = 3'd5;
  localparam logic [2:0] OP_SET_RATE = 3'd6;
  localparam logic [2:0] OP_RSVD     = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] leds;
  logic       running;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  led_count_ctrl #(.CLK_FREQ(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .leds     (leds),
    .running  (running),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Inputs applied for one clock edge, and the outputs expected right after it.
  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] leds;
    logic       run;
    logic       tick;
    logic       wrap;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [2:0] op, input logic [7:0] d,
                     input logic [7:0] l, input logic run, input logic tk, input logic wr,
                     input logic rdy);
    vec_t t;
    t.rst_n = r; t.valid = v; t.op = op; t.data = d;
    t.leds = l; t.run = run; t.tick = tk; t.wrap = wr; t.rdy = rdy;
    vecs.push_back(t);
  endtask

  task automatic idle(input int n, input logic [7:0] l, input logic run);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, OP_NOP, 8'h00, l, run, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then presents the command for the accepting edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] d);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_cmd op=%0d ready got=%b want=1 within 10 cycles", op, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    step();
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] got, want;
    logic [3:0]  rdy_pat;
    int          acc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 8'h00;
    step();

    // Reset, command ignored during reset, then 20 idle cycles.
    add(1'b0, 1'b1, OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(20, 8'h00, 1'b0);
    // LOAD FE; START held through the not-ready cycle; ticks every 8 cycles.
    add(1'b1, 1'b1, OP_LOAD,  8'hFE, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, OP_START, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, OP_START, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7, 8'hFE, 1'b1);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(7, 8'hFF, 1'b1);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    // LOAD 37 while running, then reset mid-run with a command offered.
    add(1'b1, 1'b1, OP_LOAD,  8'h37, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 8'h37, 1'b1);
    add(1'b0, 1'b1, OP_START, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 8'h00, 1'b0);
    // Pause after pre reaches 5, resume: tick 3 cycles after running rises.
    add(1'b1, 1'b1, OP_START, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5, 8'h00, 1'b1);
    add(1'b1, 1'b1, OP_STOP,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 8'h00, 1'b0);
    add(1'b1, 1'b1, OP_START, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 8'h00, 1'b1);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    // CLEAR collides with a step: no tick, pre restarts from 0.
    idle(7, 8'h01, 1'b1);
    add(1'b1, 1'b1, OP_CLEAR, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7, 8'h00, 1'b1);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
    // STOP collides with a step: step deferred to first RUN cycle after START.
    idle(7, 8'h01, 1'b1);
    add(1'b1, 1'b1, OP_STOP,  8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 8'h01, 1'b0);
    add(1'b1, 1'b1, OP_START, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    // SET_DIR collides with a step: step still uses the old (up) direction.
    idle(7, 8'h02, 1'b1);
    add(1'b1, 1'b1, OP_SET_DIR, 8'h01, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(7, 8'h03, 1'b1);
    add(1'b1, 1'b0, OP_NOP,   8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1);
    // Reserved op and START-in-RUN are accepted no-ops.
    add(1'b1, 1'b1, OP_RSVD,  8'hAA, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 8'h02, 1'b1);
    add(1'b1, 1'b1, OP_START, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; cmd_valid = vecs[i].valid;
      cmd_op = vecs[i].op;   cmd_data = vecs[i].data;
      step();
      got  = {leds, running, tick, wrap, cmd_ready};
      want = {vecs[i].leds, vecs[i].run, vecs[i].tick, vecs[i].wrap, vecs[i].rdy};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d got leds=%h run=%b tick=%b wrap=%b rdy=%b want leds=%h run=%b tick=%b wrap=%b rdy=%b",
                 i, got[11:4], got[3], got[2], got[1], got[0],
                 want[11:4], want[3], want[2], want[1], want[0]);
      end else begin
        $display("ok   vec%0d leds=%h run=%b tick=%b wrap=%b rdy=%b",
                 i, got[11:4], got[3], got[2], got[1], got[0]);
      end
    end

    // Rate 3 (P = 1), down-counting from 01: steps on every RUN cycle.
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 8'h00;
    step();
    rst_n = 1'b1;
    send_cmd(OP_SET_RATE, 8'h03);
    send_cmd(OP_SET_DIR, 8'h01);
    send_cmd(OP_LOAD, 8'h01);
    send_cmd(OP_START, 8'h00);
    check("rate3_start_leds", 32'(leds), 32'h01);
    check("rate3_start_run_tick", 32'({running, tick}), 32'b10);
    step();
    check("rate3_step1", 32'({leds, tick, wrap}), 32'({8'h00, 1'b1, 1'b0}));
    step();
    check("rate3_step2", 32'({leds, tick, wrap}), 32'({8'hFF, 1'b1, 1'b1}));
    step();
    check("rate3_step3", 32'({leds, tick, wrap}), 32'({8'hFE, 1'b1, 1'b0}));

    // Back-to-back valid: ready toggles 1,0,1,0 with two acceptances in 4 cycles.
    rdy_pat = '0;
    acc = 0;
    cmd_valid = 1'b1; cmd_op = OP_NOP;
    for (int i = 0; i < 4; i++) begin
      rdy_pat[3-i] = cmd_ready;
      if (cmd_ready === 1'b1) acc++;
      step();
    end
    cmd_valid = 1'b0;
    check("b2b_ready_pattern", 32'(rdy_pat), 32'b1010);
    check("b2b_accept_count", 32'(acc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
